// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 shift-add multiply unit owning the HI/LO register pair.
// Executes MULT/MULTU/MADD/MSUB over WIDTH+2 cycles and MTHI/MTLO in one.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Unsigned magnitude; the most-negative value maps to itself, which is exact as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = ~v + WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             op_is_mul_s;
  logic             op_signed_s;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic             sign_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    hilo_next_s;

  // Operation decode and next-state selection
  always_comb begin
    op_is_mul_s  = (Op[2] == 1'b0);
    op_signed_s  = (Op != OP_MULTU);
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start && op_is_mul_s) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CW'(1)) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FINISH: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Signed product and the HI/LO value written back at FINISH
  always_comb begin
    if (sign_r) begin
      prod_s = ~acc_r + PW'(1);
    end else begin
      prod_s = acc_r;
    end
    case (op_r)
      OP_MADD: hilo_next_s = {hi_r, lo_r} + prod_s;
      OP_MSUB: hilo_next_s = {hi_r, lo_r} - prod_s;
      default: hilo_next_s = prod_s;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, shift-add iteration and HI/LO write-back
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      sign_r   <= 1'b0;
      op_r     <= 3'b000;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            if (op_is_mul_s) begin
              mcand_r  <= {{WIDTH{1'b0}}, magnitude(A, op_signed_s)};
              mplier_r <= magnitude(B, op_signed_s);
              sign_r   <= op_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
              op_r     <= Op;
              acc_r    <= '0;
              cnt_r    <= CW'(WIDTH);
            end else if (Op == OP_MTHI) begin
              hi_r   <= A;
              done_r <= 1'b1;
            end else if (Op == OP_MTLO) begin
              lo_r   <= A;
              done_r <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mplier_r <= mplier_r >> 1;
          mcand_r  <= mcand_r << 1;
          cnt_r    <= cnt_r - CW'(1);
        end
        ST_FINISH: begin
          {hi_r, lo_r} <= hilo_next_s;
          done_r       <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed cases from the plan plus
// randomized operations scored against a plain-arithmetic HI/LO model.
module tb_hilo_mult_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int          checks;
  int          errors;
  logic [63:0] model_hilo;

  hilo_mult_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted operation on the 64-bit {HI,LO} pair
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
    longint      sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'h0, a} * {32'h0, b};
    case (op)
      3'd0:    return 64'(sp);
      3'd1:    return up;
      3'd2:    return hilo + 64'(sp);
      3'd3:    return hilo - 64'(sp);
      3'd4:    return {a, hilo[31:0]};
      3'd5:    return {hilo[63:32], a};
      default: return hilo;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_hilo = 64'h0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 7));
    model_hilo = ref_result(op, a, b, model_hilo);
    if (op[2] == 1'b0) begin
      lat = -1; busy_cnt = 0; seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        if (Busy) busy_cnt++;
        if (Done) begin
          seen = 1'b1;
          lat = k;
        end else begin
          @(negedge Clk);
        end
      end
      check({tag, "_latency"}, 64'(lat), 64'd33);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    end else begin
      check({tag, "_done"}, 64'(Done), 64'd1);
      check({tag, "_busy"}, 64'(Busy), 64'd0);
    end
    check({tag, "_hilo"}, {HI, LO}, model_hilo);
    @(negedge Clk);
    check({tag, "_done_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] corner [4];
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0; errors = 0; model_hilo = 64'h0;
    Rst = 1'b1; Start = 1'b0; Op = 3'b000; A = 32'h0; B = 32'h0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_hilo", {HI, LO}, 64'h0);

    run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg3x5_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_exact", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_minneg", 3'd0, 32'h8000_0000, 32'h8000_0000);
    check("mult_minneg_exact", {HI, LO}, 64'h4000_0000_0000_0000);

    do_reset();
    run_op("mtlo", 3'd5, 32'd10, 32'd0);
    run_op("madd", 3'd2, 32'd4, 32'd5);
    check("madd_exact", {HI, LO}, 64'h0000_0000_0000_001E);
    run_op("msub", 3'd3, 32'hFFFF_FFFF, 32'h1E);
    check("msub_exact", {HI, LO}, 64'h0000_0000_0000_003C);

    do_reset();
    run_op("msub_zero", 3'd3, 32'd1, 32'd1);
    check("msub_zero_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mthi", 3'd4, 32'h1234, 32'd0);
    check("mthi_exact", {HI, LO}, 64'h0000_1234_FFFF_FFFF);

    // back-to-back: MTLO accepted in the cycle the MTHI Done is high
    @(negedge Clk);
    Start = 1'b1; Op = 3'd4; A = 32'hAAAA_0001;
    @(negedge Clk);
    check("b2b_first_done", 64'(Done), 64'd1);
    Op = 3'd5; A = 32'h5555_0002;
    @(negedge Clk);
    Start = 1'b0;
    model_hilo = {32'hAAAA_0001, 32'h5555_0002};
    check("b2b_second_done", 64'(Done), 64'd1);
    check("b2b_hilo", {HI, LO}, model_hilo);

    // Start while busy is ignored
    do_reset();
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd7; B = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'd2; B = 32'd2;
    @(negedge Clk);
    Start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) pulses++;
      @(negedge Clk);
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_hilo", {HI, LO}, 64'h0000_0000_0000_002A);
    model_hilo = 64'h2A;

    // reset in the middle of a multiply
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    repeat (14) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_hilo = 64'h0;
    check("midreset_busy", 64'(Busy), 64'd0);
    check("midreset_hilo", {HI, LO}, 64'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) pulses++;
      @(negedge Clk);
    end
    check("midreset_no_done", 64'(pulses), 64'd0);

    // invalid op
    run_op("pre_invalid", 3'd4, 32'hCAFE_F00D, 32'd0);
    @(negedge Clk);
    Start = 1'b1; Op = 3'b110; A = 32'h1111_1111; B = 32'h2222_2222;
    @(negedge Clk);
    Start = 1'b0;
    check("invalid_done", 64'(Done), 64'd0);
    check("invalid_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    check("invalid_hilo", {HI, LO}, model_hilo);

    // randomized operations with corner-value operands mixed in
    corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h0000_0000; corner[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 5)), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
